// File: rtl/axis_elastic_fifo.sv
// AXI-Stream elastic buffer of DEPTH beats with registered tready, storage-driven
// output, synchronous flush and an explicit fill level.
module axis_elastic_fifo #(
  parameter int TDATA_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // upstream (subordinate) side
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [TDATA_WIDTH-1:0]       s_tdata,
  input  logic                         s_tlast,
  // downstream (manager) side
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [TDATA_WIDTH-1:0]       m_tdata,
  output logic                         m_tlast,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [TDATA_WIDTH:0] mem [DEPTH];
  logic [TDATA_WIDTH:0] head;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [LW-1:0]        level_q;
  logic [LW-1:0]        level_next;
  logic                 tready_q;
  logic                 push;
  logic                 pop;

  // Handshakes: a beat moves on a side only in a cycle where that side's tvalid
  // and tready are both 1 at the clock edge. tvalid never waits on tready.
  assign push = s_tvalid && tready_q;
  assign pop  = m_tvalid && m_tready;

  assign head     = mem[rd_ptr];
  assign m_tvalid = (level_q != '0);
  assign m_tdata  = head[TDATA_WIDTH-1:0];
  assign m_tlast  = head[TDATA_WIDTH];
  assign s_tready = tready_q;
  assign level    = level_q;

  // Flush wins over push/pop: a push in the flush cycle is accepted then dropped.
  always_comb begin
    level_next = level_q;
    if (flush)
      level_next = '0;
    else if (push && !pop)
      level_next = level_q + LW'(1);
    else if (pop && !push)
      level_next = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      level_q  <= level_next;
      tready_q <= (level_next < LW'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {s_tlast, s_tdata};
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_elastic_fifo.sv
// Directed bench for axis_elastic_fifo: reset, fill/backpressure, streaming,
// flush with concurrent push/pop, randomised handshakes and mid-stream reset.
module tb_axis_elastic_fifo;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int LW = $clog2(D+1);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [W-1:0]  m_tdata;
  logic          m_tlast;
  logic          flush = 1'b0;
  logic [LW-1:0] level;

  axis_elastic_fifo #(.TDATA_WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .flush    (flush),
    .level    (level)
  );

  logic [W:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (level == '0) break;
      tick();
    end
    check(name, level, 0);
  endtask

  // scoreboard: outputs are compared on the falling edge before the transfer edge
  always @(negedge clk) begin
    logic [W:0] exp;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("level_range", (level <= LW'(D)), 1);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got 0x%0h expected none at %0t", m_tdata, $time);
        end else begin
          exp = exp_q.pop_front();
          check("beat", {m_tlast, m_tdata}, exp);
        end
      end
      if (flush)
        exp_q.delete();
      else if (s_tvalid && s_tready)
        exp_q.push_back({s_tlast, s_tdata});
    end
  end

  initial begin
    int         next_beat;
    int         sent;
    logic       acc;
    logic [5:0] t2_tr;

    // reset values
    repeat (3) tick();
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_level", level, 0);
    check("rst_tdata", {m_tlast, m_tdata}, 0);
    rst_n = 1'b1;

    // T1: tready rises on the first edge, beat shows one cycle after push
    tick();
    check("t1_tready", s_tready, 1);
    check("t1_tvalid_empty", m_tvalid, 0);
    s_tvalid = 1'b1; s_tdata = 32'hA5A5_0001; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("t1_level", level, 1);
    check("t1_tvalid", m_tvalid, 1);
    check("t1_tdata", m_tdata, 64'hA5A5_0001);
    check("t1_tlast", m_tlast, 1);
    drain("t1_drain");

    // T2: no downstream ready, 6 beats offered, 4 accepted
    m_tready  = 1'b0;
    next_beat = 0;
    t2_tr     = 6'b001111;
    for (int c = 0; c < 6; c++) begin
      s_tvalid = 1'b1; s_tdata = next_beat; s_tlast = (next_beat % 7 == 6);
      check("t2_tready", s_tready, t2_tr[c]);
      acc = s_tready;
      tick();
      if (acc) next_beat++;
    end
    check("t2_accepted", next_beat, 4);
    check("t2_level", level, 4);
    check("t2_tready_full", s_tready, 0);
    check("t2_head", m_tdata, 0);

    // T3: release downstream, steady streaming at level 3
    m_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      s_tvalid = 1'b1; s_tdata = next_beat; s_tlast = (next_beat % 7 == 6);
      acc = s_tready;
      tick();
      if (acc) next_beat++;
      if (c == 0) check("t3_tready_after_pop", s_tready, 1);
      check("t3_level", level, 3);
      check("t3_tvalid", m_tvalid, 1);
    end
    check("t3_accepted", next_beat, 13);
    drain("t3_drain");

    // T4: flush at level 3 with concurrent pop of 100 and push of 103
    m_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_tvalid = 1'b1; s_tdata = 100 + k; s_tlast = 1'b0;
      tick();
    end
    check("t4_level_pre", level, 3);
    s_tvalid = 1'b1; s_tdata = 103; m_tready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; s_tvalid = 1'b0;
    check("t4_level", level, 0);
    check("t4_tvalid", m_tvalid, 0);
    check("t4_tready", s_tready, 1);
    flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_tvalid = 1'b1; s_tdata = 300 + k;
      tick();
      check("t4_hold_level", level, 0);
      check("t4_hold_tready", s_tready, 1);
    end
    flush = 1'b0;
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 200; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("t4_post_data", m_tdata, 200);
    check("t4_post_level", level, 1);
    drain("t4_drain");

    // T5: randomised valid/ready, tlast every 7th beat
    sent = 0;
    s_tvalid = 1'b0;
    for (int cyc = 0; cyc < 4000 && sent < 300; cyc++) begin
      if (!s_tvalid && $urandom_range(0, 1) == 1) begin
        s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = (sent % 7 == 6);
      end
      m_tready = ($urandom_range(0, 1) == 1);
      acc = s_tvalid && s_tready;
      tick();
      if (acc) begin
        sent++;
        s_tvalid = 1'b0;
      end
    end
    check("t5_sent", sent, 300);
    drain("t5_drain");

    // T6: asynchronous reset with 3 beats held
    m_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_tvalid = 1'b1; s_tdata = 32'h60 + k; s_tlast = 1'b0;
      tick();
    end
    s_tvalid = 1'b0;
    check("t6_level_pre", level, 3);
    #3 rst_n = 1'b0;
    #1;
    check("t6_tvalid", m_tvalid, 0);
    check("t6_tready", s_tready, 0);
    check("t6_level", level, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_no_stale", m_tvalid, 0);
    end
    s_tvalid = 1'b1; s_tdata = 32'h70; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("t6_post_data", m_tdata, 32'h70);
    drain("t6_drain");

    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
